// File: rtl/simple_bus_pkg.sv
// Shared definitions for the simple memory bus initiator.
// Contents: access size encodings, initiator FSM state enum, registered
// request payload struct, and a misalignment helper.
package simple_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  // True when the access cannot be issued: misaligned half/word or size 3.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/simple_load_align.sv
// Load data lane select and zero/sign extension.
// Ports:
//   word    - aligned 32-bit word read from the bus
//   addr_lo - byte offset within the word
//   size    - access size encoding
//   sgn     - sign-extend when 1
//   data_c  - right-aligned, extended load data (combinational)
module simple_load_align
  import simple_bus_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    data_c = word;
    case (size)
      SZ_BYTE: data_c = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_HALF: data_c = {{16{sgn & half_v[15]}}, half_v};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/simple_mem_initiator.sv
// Initiator end of the simple memory bus: takes one core load/store at a
// time, issues it on the bus, extracts/extends the read data and returns a
// single response. Misaligned or illegal-size requests get an error response
// without any bus activity.
// Optional feature macro: SIMPLE_INIT_TIMEOUT_EN (bus-ready watchdog that
// ends a request with an error after TIMEOUT_CYCLES cycles in REQ).
// Ports:
//   clock, reset (sync, active-low)
//   req_*            - core request channel (valid/ready handshake)
//   resp_*           - core response channel (valid/ready handshake)
//   simple_out_*     - bus request channel
//   simple_in_rdata  - bus read word, valid the cycle after the handshake
module simple_mem_initiator
  import simple_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        simple_out_valid,
  input  logic        simple_out_ready,
  output logic [31:0] simple_out_bits_addr,
  output logic        simple_out_bits_writeEn,
  output logic [2:0]  simple_out_bits_size,
  output logic [31:0] simple_out_bits_wdata,
  input  logic [31:0] simple_in_rdata
);

  state_e      state, state_nxt;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] load_data_c;
  logic        bad_c;
  logic        timeout_c;

  assign bad_c = misaligned(req_addr[1:0], req_size);

`ifdef SIMPLE_INIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);
  // Fires on the TIMEOUT_CYCLES-th REQ cycle that sees no ready.
  assign timeout_c = (state == ST_REQ) && !simple_out_ready &&
                     (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));

  // Watchdog counter; held at zero outside REQ so it is clear on entry.
  always_ff @(posedge clock) begin
    if (!reset)                  cnt_q <= '0;
    else if (state != ST_REQ)    cnt_q <= '0;
    else if (!simple_out_ready)  cnt_q <= cnt_inc_c;
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  simple_load_align u_align (
    .word    (simple_in_rdata),
    .addr_lo (req_q.addr[1:0]),
    .size    (req_q.size),
    .sgn     (req_q.sgn),
    .data_c  (load_data_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    simple_out_valid = 1'b0;
    resp_valid       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad_c ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        simple_out_valid = 1'b1;
        if (simple_out_ready) state_nxt = ST_CAPT;
        else if (timeout_c)   state_nxt = ST_DONE;
      end
      ST_CAPT: state_nxt = ST_DONE;
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response data registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q   <= '{addr: req_addr, wen: req_wen, size: req_size,
                         sgn: req_signed, wdata: req_wdata};
            rdata_q <= '0;
            err_q   <= bad_c;
          end
        end
        ST_REQ: begin
          if (timeout_c) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_CAPT: begin
          rdata_q <= req_q.wen ? 32'd0 : load_data_c;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata              = rdata_q;
  assign resp_err                = err_q;
  assign simple_out_bits_addr    = req_q.addr;
  assign simple_out_bits_writeEn = req_q.wen;
  assign simple_out_bits_size    = {1'b0, req_q.size};
  assign simple_out_bits_wdata   = req_q.wdata;

endmodule

// File: tb/tb_simple_mem_initiator.sv
// Self-checking bench for simple_mem_initiator: table of request vectors
// with expected responses queued at drive time and popped at response time,
// plus hand sequences for reset-in-REQ and (when enabled) the watchdog.
module tb_simple_mem_initiator;

`ifdef SIMPLE_INIT_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        simple_out_valid;
  logic        simple_out_ready;
  logic [31:0] simple_out_bits_addr;
  logic        simple_out_bits_writeEn;
  logic [2:0]  simple_out_bits_size;
  logic [31:0] simple_out_bits_wdata;
  logic [31:0] simple_in_rdata;

  simple_mem_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_addr                (req_addr),
    .req_wen                 (req_wen),
    .req_size                (req_size),
    .req_signed              (req_signed),
    .req_wdata               (req_wdata),
    .resp_valid              (resp_valid),
    .resp_ready              (resp_ready),
    .resp_rdata              (resp_rdata),
    .resp_err                (resp_err),
    .simple_out_valid        (simple_out_valid),
    .simple_out_ready        (simple_out_ready),
    .simple_out_bits_addr    (simple_out_bits_addr),
    .simple_out_bits_writeEn (simple_out_bits_writeEn),
    .simple_out_bits_size    (simple_out_bits_size),
    .simple_out_bits_wdata   (simple_out_bits_wdata),
    .simple_in_rdata         (simple_in_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bus responder: ready is combinational from valid when enabled; the read
  // word appears only in the cycle after the handshake, junk otherwise.
  logic        ready_en = 1'b0;
  logic        hs_prev  = 1'b0;
  logic [31:0] cur_mem  = 32'd0;
  assign simple_out_ready = simple_out_valid & ready_en;
  always @(posedge clock) hs_prev <= simple_out_valid & simple_out_ready;
  assign simple_in_rdata = hs_prev ? cur_mem : 32'h5A5A_5A5A;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          stall;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  vec_t  vecs[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic wen, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] mem, int stall, int hold,
                              logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.wen = wen; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.mem = mem; v.stall = stall; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic do_req(input vec_t v);
    resp_t e;
    resp_t got;
    int    lat;
    int    busv;
    int    exp_lat;
    int    exp_busv;
    bit    bus;
    bit    done;
    bus      = !v.exp_err;
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    exp_lat  = bus ? 3 + v.stall : 1;
    exp_busv = bus ? v.stall + 1 : 0;
    if (bus && v.stall >= TMO) begin
      e.rdata  = 32'd0;
      e.err    = 1'b1;
      exp_lat  = 1 + TMO;
      exp_busv = TMO;
    end
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_wen    = v.wen;
    req_size   = v.size;
    req_signed = v.sgn;
    req_wdata  = v.wdata;
    cur_mem    = v.mem;
    ready_en   = 1'b0;
    resp_ready = (v.hold == 0);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    // Scramble the request inputs so only registered fields can be used.
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wen    = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_wdata  = $urandom;
    lat  = 0;
    busv = 0;
    done = 0;
    while (!done && lat < 80) begin
      @(negedge clock);
      lat++;
      if (simple_out_valid) begin
        busv++;
        chk("bus_addr",  simple_out_bits_addr, v.addr);
        chk("bus_wen",   32'(simple_out_bits_writeEn), 32'(v.wen));
        chk("bus_size",  32'(simple_out_bits_size), {30'd0, v.size});
        chk("bus_wdata", simple_out_bits_wdata, v.wdata);
      end
      if (resp_valid) done = 1;
      else            ready_en = (lat > v.stall);
    end
    ready_en = 1'b0;
    if (!done) chk("resp_wait_expired", 32'd0, 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("bus_valid_cycles", 32'(busv), 32'(exp_busv));
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("resp_rdata", resp_rdata, got.rdata);
      chk("resp_err", 32'(resp_err), 32'(got.err));
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clock);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_rdata", resp_rdata, got.rdata);
        chk("hold_err", 32'(resp_err), 32'(got.err));
      end
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk("back_idle_valid", 32'(resp_valid), 32'd0);
    chk("back_idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_time_limit actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    req_wen    = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    //       wen size sgn addr          wdata         mem           stall hold exp_rdata     err
    vecs.push_back(mk(0, 2'd2, 0, 32'h8000_0000, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h8000_0003, 32'h0,        32'h80FF1234, 0, 0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h8000_0003, 32'h0,        32'h80FF1234, 0, 0, 32'h00000080, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h8000_0002, 32'h0000ABCD, 32'h11112222, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h8000_0001, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 2'd2, 0, 32'h8000_0004, 32'h0,        32'h12345678, 5, 4, 32'h12345678, 0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h8000_0002, 32'h0,        32'h80017FFF, 0, 0, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h8000_0000, 32'h0,        32'h8001F00D, 1, 0, 32'hFFFFF00D, 0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h8000_0000, 32'h0,        32'h8001F00D, 0, 0, 32'h0000F00D, 0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h8000_0001, 32'h0,        32'h8001F00D, 0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 2'd3, 0, 32'h8000_0000, 32'h0,        32'h8001F00D, 0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 2'd0, 1, 32'h8000_0001, 32'h0,        32'h11223344, 0, 0, 32'h00000033, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h8000_0002, 32'h0,        32'hAABBCCDD, 0, 2, 32'h000000BB, 0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h8000_0008, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 0, 32'h0,        0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h8000_0002, 32'h00000001, 32'hFFFFFFFF, 0, 0, 32'h0,        1));
    vecs.push_back(mk(1, 2'd0, 0, 32'h8000_0005, 32'h000000A5, 32'h12345678, 0, 0, 32'h0,        0));
`ifdef SIMPLE_INIT_TIMEOUT_EN
    // Bus never ready: watchdog must end it with an error.
    vecs.push_back(mk(0, 2'd2, 0, 32'h8000_0010, 32'h0,        32'h0BADF00D, 1000, 0, 32'h0,     1));
`endif

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_out_valid",  32'(simple_out_valid), 32'd0);
    chk("rst_rdata",      resp_rdata, 32'd0);
    chk("rst_err",        32'(resp_err), 32'd0);
    chk("rst_bus_addr",   simple_out_bits_addr, 32'd0);
    chk("rst_bus_wdata",  simple_out_bits_wdata, 32'd0);
    chk("rst_bus_size",   32'(simple_out_bits_size), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // Reset while stalled in REQ: bus request dropped and not retried.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wen   = 1'b0;
    req_size  = 2'd2;
    ready_en  = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    chk("rstreq_out_valid_before", 32'(simple_out_valid), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("rstreq_out_valid_after", 32'(simple_out_valid), 32'd0);
    chk("rstreq_req_ready",       32'(req_ready), 32'd1);
    chk("rstreq_resp_valid",      32'(resp_valid), 32'd0);
    chk("rstreq_bus_addr",        simple_out_bits_addr, 32'd0);
    ready_en = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rstreq_no_retry", 32'(simple_out_valid | resp_valid), 32'd0);
    end
    ready_en = 1'b0;

    // Normal operation after the abandoned transaction.
    do_req(mk(0, 2'd2, 0, 32'h8000_0024, 32'h0, 32'h76543210, 0, 0, 32'h76543210, 0));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_mem_initiator.md
# simple_mem_initiator

Initiator (master) end of the simple memory bus: accepts one load/store request at a time from the core's LSU/IFU side and drives it onto the simple bus. It extracts and extends the returned read data and hands back a single response. It sits between the core pipeline and the bus responder. Misaligned requests are rejected with an error and never reach the bus.

## Interface
- `TIMEOUT_CYCLES`, default 64: bus-ready watchdog limit; used only with the timeout feature.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in 32: byte address.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: log2 of access bytes; 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed` in 1: sign-extend load data when 1.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response available; held until `resp_ready`.
- `resp_ready` in 1: core accepts response.
- `resp_rdata` out 32: extracted/extended load data; 0 for stores.
- `resp_err` out 1: misaligned/illegal (or timeout) error, qualified by `resp_valid`.
- `simple_out_valid` out 1: bus request valid.
- `simple_out_ready` in 1: bus accept.
- `simple_out_bits_addr` out 32: unmodified byte address.
- `simple_out_bits_writeEn` out 1: store.
- `simple_out_bits_size` out 3: `{1'b0, req_size}`.
- `simple_out_bits_wdata` out 32: right-aligned store data.
- `simple_in_rdata` in 32: aligned word at `addr & ~3`; valid the cycle after the handshake.

## Operation
- FSM states: IDLE, REQ, CAPT, DONE.
- IDLE:
  - On `req_valid`, register all request fields.
  - If the request is misaligned (half with `addr[0]`=1; word with `addr[1:0]`≠0) or `req_size`=3: go to DONE with err=1 and rdata=0. No bus activity.
  - Otherwise go to REQ.
- REQ: `simple_out_valid`=1, bus fields driven from the registers. On `simple_out_ready` go to CAPT; otherwise stay, with fields held stable.
- CAPT: sample `simple_in_rdata` and go to DONE.
  - Loads: select the lane by `addr[1:0]` (byte: `[8*a+7:8*a]`; half: `[16*a[1]+15:16*a[1]]`). Zero- or sign-extend per `req_signed`.
  - Stores: rdata=0.
- DONE: `resp_valid`=1. On `resp_ready` go to IDLE. Response outputs are stable while waiting.
- Only one request is outstanding at a time; no pipelining.
- Reset values: state IDLE; `req_ready`=1 (IDLE decode); `resp_valid`=0; `resp_rdata`=0; `resp_err`=0; `simple_out_valid`=0; all bus fields 0.

## Timing
- Request accepted on edge 0. `simple_out_valid` is high in cycle 1.
- If ready is combinational from valid, the handshake occurs on edge 1, CAPT occurs in cycle 2, and `resp_valid` is first seen in cycle 3. Minimum latency: 3 cycles from accept to response.
- Each stalled bus cycle adds 1 cycle.
- Error path: `resp_valid` in cycle 1.
- `resp_valid & resp_ready` in DONE returns to IDLE. The next request can be accepted the following cycle; there is no same-cycle turnaround.
- Reset asserted in any state: IDLE on the next edge, and `simple_out_valid` drops in that cycle. An abandoned bus transaction is not retried.

## Configuration
- `SIMPLE_INIT_TIMEOUT_EN` defined: a counter runs in REQ, cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` without `simple_out_ready`, go to DONE with err=1 and rdata=0, and deassert `simple_out_valid`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Undefined: no counter; REQ waits indefinitely.

## Structure
- Shared package `simple_bus_pkg`:
  - size encodings (`SZ_BYTE`/`SZ_HALF`/`SZ_WORD`);
  - FSM state enum;
  - request struct (addr, wen, size, signed, wdata).
- One sub-module, `simple_load_align`: combinational lane select plus extension (inputs: word, addr[1:0], size, signed).

## Test plan
- Load word at 0x80000000, memory 0xDEADBEEF, ready tied to valid → bus valid for 1 cycle with size=2; `resp_rdata`=0xDEADBEEF, err=0, 3 cycles after accept.
- Signed byte load at 0x80000003, word 0x80FF1234 → `resp_rdata`=0xFFFFFF80. Same load unsigned → 0x00000080.
- Store half 0xABCD to 0x80000002 → bus writeEn=1, size=1, wdata=0x0000ABCD, addr unmodified; `resp_rdata`=0, err=0.
- Word load at 0x80000001 → no `simple_out_valid` ever; `resp_valid`+`resp_err` in cycle 1.
- Ready held low for 5 cycles, then high → bus fields stable throughout; response 8 cycles after accept. Hold `resp_ready` low for 4 cycles → outputs stable and `req_ready`=0.
- Reset pulled low while in REQ → `simple_out_valid`=0 and state IDLE after 1 edge. With `SIMPLE_INIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, ready never asserted → err response after 4 REQ cycles.
